// File: rtl/ca_line_gen_if.sv
// Write-side bundle between the cellular-automaton line generator and the
// line-addressed image memory / pixel reader.
interface ca_line_gen_if #(
    parameter int WIDTH = 80
);
    logic             start;
    logic             step;
    logic [7:0]       rule;
    logic [WIDTH-1:0] seed;
    logic [6:0]       rd_row;
    logic [6:0]       rowW;
    logic [WIDTH-1:0] dataW;
    logic [6:0]       top_row;
    logic             busy;
    logic [15:0]      gen_count;

    // Controller / memory side: issues commands and the reader row, observes the write port.
    modport master (
        output start, step, rule, seed, rd_row,
        input  rowW, dataW, top_row, busy, gen_count
    );

    // Generator side.
    modport slave (
        input  start, step, rule, seed, rd_row,
        output rowW, dataW, top_row, busy, gen_count
    );
endinterface

// File: rtl/ca_line_gen.sv
// Elementary cellular-automaton line generator. Each generation is presented
// as a full line on rowW/dataW and held until the write-enable-less image
// memory is known to have taken it (rowW != rd_row on a clock edge).
module ca_line_gen #(
    parameter int WIDTH = 80,
    parameter int ROWS  = 60,
    parameter int WRAP  = 1
) (
    input logic         clk,
    input logic         rst,
    ca_line_gen_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

    // Row index after r, wrapping ROWS-1 -> 0.
    function automatic logic [6:0] row_inc(input logic [6:0] r);
        return (r == LAST_ROW) ? 7'd0 : r + 7'd1;
    endfunction

    // One generation step: cell i looks up rule bit {left, centre, right},
    // with bit 0 as the leftmost column.
    function automatic logic [WIDTH-1:0] next_gen(input logic [7:0]       r,
                                                  input logic [WIDTH-1:0] old);
        logic [WIDTH-1:0] nxt;
        logic             l;
        logic             c;
        logic             rt;
        nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = old[i];
            if (i == 0) l = (WRAP != 0) ? old[WIDTH-1] : 1'b0;
            else        l = old[i-1];
            if (i == WIDTH - 1) rt = (WRAP != 0) ? old[0] : 1'b0;
            else                rt = old[i+1];
            nxt[i] = r[{l, c, rt}];
        end
        return nxt;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       row_q,   row_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [6:0]       top_q,   top_d;
    logic             busy_q,  busy_d;
    logic [15:0]      gen_q,   gen_d;
    logic [7:0]       rule_q,  rule_d;
    logic             fill_q,  fill_d;

    logic             committed;
    logic [WIDTH-1:0] data_next;

    // The memory writes on exactly this condition, so it doubles as our commit.
    assign committed = (row_q != bus.rd_row);
    assign data_next = next_gen(rule_q, data_q);

    // State and datapath registers; every output is registered so rowW and
    // dataW always move on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed by the comb block.
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            data_q  <= '0;
            top_q   <= '0;
            busy_q  <= 1'b0;
            gen_q   <= '0;
            rule_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            data_q  <= data_d;
            top_q   <= top_d;
            busy_q  <= busy_d;
            gen_q   <= gen_d;
            rule_q  <= rule_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic: start restarts from the seed from any state; step is
    // accepted only in IDLE; COMMIT stalls until the line has been written.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case/if tree can leave one unassigned and infer a latch.
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        top_d   = top_q;
        busy_d  = busy_q;
        gen_d   = gen_q;
        rule_d  = rule_q;
        fill_d  = fill_q;

        if (bus.start) begin
            rule_d  = bus.rule;
            row_d   = '0;
            data_d  = bus.seed;
            fill_d  = 1'b1;
            gen_d   = '0;
            top_d   = '0;
            busy_d  = 1'b1;
            state_d = COMMIT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.step) begin
                        row_d   = row_inc(row_q);
                        data_d  = data_next;
                        busy_d  = 1'b1;
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    if (committed) begin
                        if (fill_q) begin
                            if (row_q != LAST_ROW) begin
                                row_d  = row_q + 7'd1;
                                data_d = data_next;
                                // The seed line is generation 0 and was counted at start.
                                if (row_q != 7'd0) gen_d = gen_q + 16'd1;
                            end else begin
                                fill_d  = 1'b0;
                                gen_d   = gen_q + 16'd1;
                                top_d   = '0;
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end else begin
                            // Scroll: the row after the newest line now holds the oldest.
                            gen_d   = gen_q + 16'd1;
                            top_d   = row_inc(row_q);
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rowW      = row_q;
    assign bus.dataW     = data_q;
    assign bus.top_row   = top_q;
    assign bus.busy      = busy_q;
    assign bus.gen_count = gen_q;

endmodule

// File: tb/tb_ca_line_gen.sv
// Directed bench for ca_line_gen: a vector table for the start of a rule-90
// fill, then hand-written sequences for stalls, scrolling, wrap and reset.
module tb_ca_line_gen;

    localparam int W = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ca_line_gen_if #(.WIDTH(W)) bus1 ();
    ca_line_gen_if #(.WIDTH(W)) bus0 ();

    ca_line_gen #(.WIDTH(W), .ROWS(60), .WRAP(1)) dut_wrap (.clk(clk), .rst(rst), .bus(bus1));
    ca_line_gen #(.WIDTH(W), .ROWS(60), .WRAP(0)) dut_flat (.clk(clk), .rst(rst), .bus(bus0));

    // The flat-edge instance sees the same stimulus as the toroidal one.
    assign bus0.start  = bus1.start;
    assign bus0.step   = bus1.step;
    assign bus0.rule   = bus1.rule;
    assign bus0.seed   = bus1.seed;
    assign bus0.rd_row = bus1.rd_row;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic         start;
        logic         step;
        logic [7:0]   rule;
        logic [W-1:0] seed;
        logic [6:0]   rd;
        logic [6:0]   e_row;
        logic [W-1:0] e_data;
        logic         e_busy;
        logic [15:0]  e_gen;
        logic [6:0]   e_top;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [W-1:0] b(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference generation step built from shifted neighbour vectors.
    function automatic logic [W-1:0] model_next(input logic [7:0] r, input logic [W-1:0] old,
                                                input bit wrap);
        logic [W-1:0] lft, rgt, n;
        lft = old << 1;
        rgt = old >> 1;
        if (wrap) begin
            lft[0]   = old[W-1];
            rgt[W-1] = old[0];
        end
        for (int i = 0; i < W; i++) n[i] = r[{lft[i], old[i], rgt[i]}];
        return n;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [6:0] row, input logic busy,
                               input logic [15:0] gen, input logic [6:0] top);
        check({tag, " rowW"},      W'(bus1.rowW),      W'(row));
        check({tag, " busy"},      W'(bus1.busy),      W'(busy));
        check({tag, " gen_count"}, W'(bus1.gen_count), W'(gen));
        check({tag, " top_row"},   W'(bus1.top_row),   W'(top));
    endtask

    logic [W-1:0] m_line;
    logic [W-1:0] gen60;
    int           hits;

    initial begin
        bus1.start  = 1'b0;
        bus1.step   = 1'b0;
        bus1.rule   = 8'd0;
        bus1.seed   = '0;
        bus1.rd_row = 7'd59;

        // Rule 90 from a single centre cell; rule/seed changes and a step
        // pulse mid-fill must have no effect.
        vecs[0] = '{1'b1, 1'b0, 8'd90,  b(40),   7'd59, 7'd0, b(40),                         1'b1, 16'd0, 7'd0};
        vecs[1] = '{1'b0, 1'b0, 8'd90,  '0,      7'd59, 7'd1, b(39) | b(41),                 1'b1, 16'd0, 7'd0};
        vecs[2] = '{1'b0, 1'b0, 8'd90,  '0,      7'd59, 7'd2, b(38) | b(42),                 1'b1, 16'd1, 7'd0};
        vecs[3] = '{1'b0, 1'b0, 8'd90,  '0,      7'd59, 7'd3, b(37) | b(39) | b(41) | b(43), 1'b1, 16'd2, 7'd0};
        vecs[4] = '{1'b0, 1'b0, 8'hFF,  b(3),    7'd59, 7'd4, b(36) | b(44),                 1'b1, 16'd3, 7'd0};
        vecs[5] = '{1'b0, 1'b1, 8'hFF,  b(3),    7'd59, 7'd5, b(35) | b(37) | b(43) | b(45), 1'b1, 16'd4, 7'd0};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_state("reset", 7'd0, 1'b0, 16'd0, 7'd0);
        check("reset dataW", bus1.dataW, '0);

        for (int i = 0; i < 6; i++) begin
            bus1.start  = vecs[i].start;
            bus1.step   = vecs[i].step;
            bus1.rule   = vecs[i].rule;
            bus1.seed   = vecs[i].seed;
            bus1.rd_row = vecs[i].rd;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_row, vecs[i].e_busy, vecs[i].e_gen, vecs[i].e_top);
            check($sformatf("vec%0d dataW", i), bus1.dataW, vecs[i].e_data);
        end
        bus1.start = 1'b0;
        bus1.step  = 1'b0;

        // Remaining rows commit one per clock against the model.
        m_line = vecs[5].e_data;
        for (int r = 6; r < 60; r++) begin
            tick();
            m_line = model_next(8'd90, m_line, 1'b1);
            check($sformatf("r90 row%0d rowW", r), W'(bus1.rowW), W'(r));
            check($sformatf("r90 row%0d dataW", r), bus1.dataW, m_line);
        end

        // Row 59 stalls while the reader sits on it.
        for (int k = 0; k < 3; k++) begin
            tick();
            check_state("r90 stall59", 7'd59, 1'b1, 16'd58, 7'd0);
            check("r90 stall59 dataW", bus1.dataW, m_line);
        end
        bus1.rd_row = 7'd10;
        tick();
        check_state("r90 filled", 7'd59, 1'b0, 16'd59, 7'd0);
        check("r90 filled dataW", bus1.dataW, m_line);

        // Scroll one line; a second step while busy is dropped, not queued.
        gen60       = model_next(8'd90, m_line, 1'b1);
        bus1.rd_row = 7'd20;
        bus1.step   = 1'b1;
        tick();
        check_state("step issue", 7'd0, 1'b1, 16'd59, 7'd0);
        check("step issue dataW", bus1.dataW, gen60);
        tick();
        check_state("step commit", 7'd0, 1'b0, 16'd60, 7'd1);
        bus1.step = 1'b0;
        tick();
        check_state("step not queued", 7'd0, 1'b0, 16'd60, 7'd1);
        check("step not queued dataW", bus1.dataW, gen60);

        // Start during a stalled step restarts from the new seed.
        bus1.rd_row = 7'd1;
        bus1.step   = 1'b1;
        tick();
        bus1.step = 1'b0;
        tick();
        check_state("step stall", 7'd1, 1'b1, 16'd60, 7'd1);
        bus1.start = 1'b1;
        bus1.seed  = b(7);
        bus1.rule  = 8'd90;
        tick();
        bus1.start = 1'b0;
        check_state("restart", 7'd0, 1'b1, 16'd0, 7'd0);
        check("restart dataW", bus1.dataW, b(7));

        // Rule 30, full unstalled fill: exactly 60 edges from start to idle.
        bus1.rd_row = 7'd127;
        bus1.rule   = 8'd30;
        bus1.seed   = b(40);
        bus1.start  = 1'b1;
        tick();
        bus1.start = 1'b0;
        m_line = b(40);
        check("r30 row0 dataW", bus1.dataW, m_line);
        for (int r = 1; r < 60; r++) begin
            tick();
            m_line = model_next(8'd30, m_line, 1'b1);
            if (r == 1) check("r30 row1 hand", bus1.dataW, b(39) | b(40) | b(41));
            if (r == 2) check("r30 row2 hand", bus1.dataW, b(38) | b(39) | b(42));
            check($sformatf("r30 row%0d dataW", r), bus1.dataW, m_line);
            check($sformatf("r30 row%0d busy", r), W'(bus1.busy), W'(1));
        end
        tick();
        check_state("r30 done", 7'd59, 1'b0, 16'd59, 7'd0);

        // Edge cells: toroidal versus zero-padded neighbours.
        bus1.rule  = 8'd90;
        bus1.seed  = b(0);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        check("wrap1 row1", bus1.dataW, b(79) | b(1));
        check("wrap0 row1", bus0.dataW, b(1));
        check("wrap0 rowW", W'(bus0.rowW), W'(1));

        // Reader parked on row 3: stall length equals hold time.
        bus1.rd_row = 7'd3;
        bus1.seed   = b(40);
        bus1.start  = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        tick();
        tick();
        check_state("hold3 arrive", 7'd3, 1'b1, 16'd2, 7'd0);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus1.rowW == 7'd3 && bus1.dataW == vecs[3].e_data) hits++;
        end
        check("hold3 stall count", W'(hits), W'(5));
        bus1.rd_row = 7'd4;
        tick();
        check_state("hold3 release", 7'd4, 1'b1, 16'd3, 7'd0);
        check("hold3 release dataW", bus1.dataW, vecs[4].e_data);
        tick();
        check_state("hold4 stall", 7'd4, 1'b1, 16'd3, 7'd0);

        // Reset mid-fill, then a step under the cleared rule.
        bus1.rd_row = 7'd127;
        bus1.start  = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (bus1.rowW == 7'd25) break;
            tick();
        end
        check("rst reach row25", W'(bus1.rowW), W'(25));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("rst mid", 7'd0, 1'b0, 16'd0, 7'd0);
        check("rst mid dataW", bus1.dataW, '0);
        bus1.step = 1'b1;
        tick();
        bus1.step = 1'b0;
        check_state("rst step issue", 7'd1, 1'b1, 16'd0, 7'd0);
        check("rst step dataW", bus1.dataW, '0);
        tick();
        check_state("rst step commit", 7'd1, 1'b0, 16'd1, 7'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ca_line_gen.md
Name: ca_line_gen

Overview:
- Upstream generator for the 60x80 line-addressed image memory feeding the VGA pixel reader.
- Computes successive generations of a 1-D elementary cellular automaton (Wolfram rule) and presents each generation as a full 80-bit line on rowW/dataW.
- The image memory has no write enable. It writes {rowW, dataW} on every clock edge where rowW != the reader's current row. This block therefore holds each line until that write is known to have landed, then advances.

Parameters:
- WIDTH, 80, cells per line / bits of dataW.
- ROWS, 60, lines in image memory; row index wraps ROWS-1 -> 0.
- WRAP, 1, 1 = toroidal neighbours (cell -1 = cell WIDTH-1, cell WIDTH = cell 0); 0 = out-of-range neighbours read as 0.

Ports:
- clk  in  1  system clock (pixel clock domain shared with image memory).
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: restart from seed, refill all ROWS lines.
- step  in  1  single-cycle pulse: generate one further line (scroll mode).
- rule  in  8  Wolfram rule number, sampled only on accepted start.
- seed  in  WIDTH  generation-0 line, sampled only on accepted start.
- rd_row  in  7  row currently addressed by the pixel reader (same signal as the memory read row).
- rowW  out  7  row being written; drives memory rowW.
- dataW  out  WIDTH  line being written; drives memory dataW.
- top_row  out  7  memory row holding the oldest generation (display offset for the reader).
- busy  out  1  high while in FILL or STEP commit.
- gen_count  out  16  generation number of the last committed line.

Behaviour:
- Reset: state IDLE; rowW=0, dataW=0, top_row=0, busy=0, gen_count=0, rule_q=0, fill=0. Zeroing row 0 during reset is intended.
- rowW and dataW always change together on the same edge. They are registered outputs, never combinational.
- Next-gen function: new[i] = rule_q[{old[i-1], old[i], old[i+1]}], index 4*left + 2*centre + right. Column 0 is leftmost. Edge cells follow WRAP.
- Commit condition: at each clk edge while in COMMIT, committed = (rowW != rd_row). This is exactly the memory's own write condition, so a line is committed on the edge where it is true.
- States: IDLE, COMMIT.
- start accept (any state, priority over step and over any in-progress operation):
  - Next edge: rule_q=rule, rowW=0, dataW=seed, fill=1, gen_count=0, top_row=0, busy=1, go to COMMIT.
- step accept (IDLE only; ignored while busy, not queued):
  - Next edge: rowW = (rowW+1) mod ROWS, dataW = f(dataW), busy=1, go to COMMIT.
- COMMIT, not committed: hold all outputs (stall). No timeout.
- COMMIT, committed, fill=1, rowW < ROWS-1:
  - Same edge: rowW+1, dataW = f(dataW), gen_count+1 (except on seed commit), stay in COMMIT.
  - Unstalled throughput is 1 line/clock; a full fill takes 60 clocks minimum.
- COMMIT, committed, fill=1, rowW = ROWS-1: fill=0, gen_count+1, top_row=0, busy=0, go to IDLE.
- COMMIT, committed, fill=0 (step): gen_count+1, top_row = (rowW+1) mod ROWS, busy=0, go to IDLE.
- IDLE: outputs held. The memory rewrites the last line with identical data, which is harmless.
- gen_count wraps at 2^16.
- rule and seed changes outside an accepted start have no effect.
- rst mid-FILL or mid-STEP returns to the reset state immediately. Rows not yet rewritten keep stale contents until the next start.

Test Plan:
- rule=90, seed=bit40 only, start, rd_row=59 constant -> row0=bit40; row1=bits39,41; row2=bits38,42. Rows 0..58 commit on consecutive clocks. Row 59 stalls one clock per edge while rd_row=59, so set rd_row=10 to release. After fill: busy=0, gen_count=59, top_row=0.
- rule=30, seed=bit40, start -> row1 = bits 39,40,41; row2 = bits 38,39,42 (check against a bench model over all 60 rows).
- WRAP=1, rule=90, seed=bit0 -> row1 = bits 79 and 1. WRAP=0, same stimulus -> row1 = bit1 only.
- rd_row held at 3 during fill -> rowW=3 held with stable dataW. Release rd_row=4 -> row 3 commits on that edge, then row 4 stalls. Stall count must equal hold duration.
- After fill, step pulse with rd_row=20 -> rowW=0, dataW = gen60 line, top_row=1, gen_count=60. A step pulse while busy is ignored. start mid-step restarts at rowW=0 with dataW=seed.
- Assert rst while rowW=25 in fill -> next edge rowW=0, dataW=0, busy=0, gen_count=0. step then writes row 1 with f(0) under rule_q=0, i.e. all zeros.
